sha_job_scheduler: RTL

Round-robin scheduler that shares one SHA-2 message-schedule unit and hash core between NUM_REQ message requesters. It grants one job at a time and programs the schedule unit's SHA type and enable. It then routes the granted requester's 512-bit AXI stream to the schedule unit until tlast and waits for the hash core's completion before re-arbitrating. It sits between the requester-side stream interfaces and the schedule-unit slave stream port.

---
 rtl/sha_job_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sha_job_scheduler.sv
// ---------------------------------------------------------------------------
// sha_job_scheduler
//   Round-robin job scheduler that time-shares one SHA-2 message-schedule unit
//   and hash core between NUM_REQ requesters. One job at a time: arbitrate,
//   pulse grant/enable, pass the winner's stream through until tlast, then
//   hold off until the core reports the digest done.
//
// Ports
//   axi_aclk, reset          clock, synchronous active-high reset
//   req_valid/req_sha_type   per-requester job request and SHA type (2b each)
//   req_grant                one-hot grant pulse (GRANT cycle)
//   s_axis_*                 requester-side streams, slice i per requester
//   wt_en/wt_sha_type        schedule-unit enable pulse and job SHA type
//   m_axis_*                 stream to the schedule unit (combinational mux)
//   core_done                hash core finished the current message
//   job_done/job_id          completion pulse and current/last job index
//   busy                     any state other than IDLE
//   blk_count                completed 512/1024-bit blocks, saturating
//   err                      [0] tlast mid 1024-bit block, [1] stray core_done
// ---------------------------------------------------------------------------
module sha_job_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 512,
   parameter int REQ_ID_WIDTH = 2
) (
   input  logic                            axi_aclk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [2*NUM_REQ-1:0]            req_sha_type,
   output logic [NUM_REQ-1:0]              req_grant,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [NUM_REQ-1:0]              s_axis_tvalid,
   output logic [NUM_REQ-1:0]              s_axis_tready,
   input  logic [NUM_REQ-1:0]              s_axis_tlast,
   output logic                            wt_en,
   output logic [1:0]                      wt_sha_type,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   input  logic                            core_done,
   output logic                            job_done,
   output logic [REQ_ID_WIDTH-1:0]         job_id,
   output logic                            busy,
   output logic [15:0]                     blk_count,
   output logic [1:0]                      err
);

   typedef enum logic [1:0] {IDLE, GRANT, STREAM, WAIT_DONE} state_t;

   state_t                  state, state_nxt;
   logic [REQ_ID_WIDTH-1:0] rr_ptr;
   logic [REQ_ID_WIDTH-1:0] winner;
   logic                    found;
   logic                    beat_par;   // 1 = next beat closes a 1024-bit block
   logic                    hs;
   logic                    sel_tlast;

   // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = REQ_ID_WIDTH'(idx);
         end
      end
   end

   // Stream pass-through: only live in STREAM, zero elsewhere.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      sel_tlast     = s_axis_tlast[job_id];
      if (state == STREAM) begin
         m_axis_tdata          = s_axis_tdata[int'(job_id)*DATA_WIDTH +: DATA_WIDTH];
         m_axis_tvalid         = s_axis_tvalid[job_id];
         m_axis_tlast          = sel_tlast;
         s_axis_tready[job_id] = m_axis_tready;
      end
   end

   assign hs = m_axis_tvalid && m_axis_tready;

   // Next state and pulse outputs.
   always_comb begin
      state_nxt = state;
      req_grant = '0;
      wt_en     = 1'b0;
      job_done  = 1'b0;
      case (state)
         IDLE:      if (found) state_nxt = GRANT;
         GRANT: begin
            wt_en             = 1'b1;
            req_grant[job_id] = 1'b1;
            state_nxt         = STREAM;
         end
         STREAM:    if (hs && sel_tlast) state_nxt = WAIT_DONE;
         WAIT_DONE: if (core_done) begin
            job_done  = 1'b1;
            state_nxt = IDLE;
         end
         default:   state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge axi_aclk) begin
      if (reset) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         job_id      <= '0;
         wt_sha_type <= 2'b00;
         blk_count   <= '0;
         beat_par    <= 1'b0;
         err         <= 2'b00;
      end else begin
         state <= state_nxt;

         // A core_done outside WAIT_DONE is flagged but never sequences.
         if (core_done && state != WAIT_DONE) err[1] <= 1'b1;

         case (state)
            IDLE: if (found) begin
               job_id      <= winner;
               wt_sha_type <= req_sha_type[2*int'(winner) +: 2];
               blk_count   <= '0;
               beat_par    <= 1'b0;
               err         <= 2'b00;
            end
            GRANT: rr_ptr <= (job_id == REQ_ID_WIDTH'(NUM_REQ-1)) ? '0 : job_id + 1'b1;
            STREAM: if (hs) begin
               // 384/512 consume two 512-bit beats per block.
               if (!wt_sha_type[1] || beat_par) begin
                  if (blk_count != 16'hFFFF) blk_count <= blk_count + 16'd1;
               end
               if (wt_sha_type[1]) beat_par <= ~beat_par;
               if (sel_tlast && wt_sha_type[1] && !beat_par) err[0] <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
